// File: rtl/window_3x3_generator_pkg.sv
// Shared widths, padding constant, default frame size and state encoding
// for the 3x3 window generator.
package window_3x3_generator_pkg;

    localparam int PIX_W          = 24;
    localparam int DEFAULT_WIDTH  = 512;
    localparam int DEFAULT_HEIGHT = 512;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam pixel_t PAD_PIXEL = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/window_3x3_generator_line_buffer.sv
// One-line circular buffer: combinational read and synchronous write on the
// same address, so a write cycle returns the word being replaced.
module line_buffer
    import window_3x3_generator_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_WIDTH,
    parameter int DATA_W = PIX_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    // NOTE: storage arrays get no reset; border padding hides unwritten words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_3x3_generator.sv
// Raster-order RGB stream to 3x3 neighbourhood generator with PAD borders
// and an internal flush that emits the final row after the last pixel.
module window_3x3_generator
    import window_3x3_generator_pkg::*;
#(
    parameter int     WIDTH  = DEFAULT_WIDTH,
    parameter int     HEIGHT = DEFAULT_HEIGHT,
    parameter pixel_t PAD    = PAD_PIXEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel_1,
    output logic [PIX_W-1:0] out_pixel_2,
    output logic [PIX_W-1:0] out_pixel_3,
    output logic [PIX_W-1:0] out_pixel_4,
    output logic [PIX_W-1:0] out_pixel_5,
    output logic [PIX_W-1:0] out_pixel_6,
    output logic [PIX_W-1:0] out_pixel_7,
    output logic [PIX_W-1:0] out_pixel_8,
    output logic [PIX_W-1:0] out_pixel_9,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    // Row counter runs two past the frame so flush steps keep the same geometry.
    localparam int RW = $clog2(HEIGHT + 2);

    localparam logic [CW-1:0] LAST_COL      = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW      = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] FLUSH_END_ROW = RW'(HEIGHT + 1);

    state_e            state_q;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              frame_done_q;
    pixel_t [1:0]      top_q, mid_q, bot_q;
    pixel_t [8:0]      win_q, win_d;

    logic              step;
    logic              emit;
    pixel_t            step_pixel;
    pixel_t            buf0_rd, buf1_rd;
    logic [RW-1:0]     cen_r;
    logic [CW-1:0]     cen_c;

    assign step       = (state_q == ST_STREAM && in_valid && in_ready_q) || (state_q == ST_FLUSH);
    assign step_pixel = (state_q == ST_FLUSH) ? PAD : in_pixel;

    line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_buf0 (
        .clk   (clk),
        .we    (step),
        .addr  (col_q),
        .wdata (step_pixel),
        .rdata (buf0_rd)
    );

    line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_buf1 (
        .clk   (clk),
        .we    (step),
        .addr  (col_q),
        .wdata (buf0_rd),
        .rdata (buf1_rd)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        col_d = col_q;
        row_d = row_q;
        if (step) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // The centre trails the incoming pixel by one line plus one column.
    always_comb begin
        cen_r = (col_q == '0) ? row_q - RW'(2) : row_q - RW'(1);
        cen_c = (col_q == '0) ? LAST_COL : col_q - CW'(1);
        emit  = step && ((row_q >= RW'(2)) || (row_q == RW'(1) && col_q != '0));

        win_d    = '0;
        win_d[0] = top_q[1];
        win_d[1] = top_q[0];
        win_d[2] = buf1_rd;
        win_d[3] = mid_q[1];
        win_d[4] = mid_q[0];
        win_d[5] = buf0_rd;
        win_d[6] = bot_q[1];
        win_d[7] = bot_q[0];
        win_d[8] = step_pixel;

        if (cen_r == '0) begin
            win_d[0] = PAD; win_d[1] = PAD; win_d[2] = PAD;
        end
        if (cen_r == LAST_ROW) begin
            win_d[6] = PAD; win_d[7] = PAD; win_d[8] = PAD;
        end
        // Column padding also hides the previous/next line sitting in the shift registers.
        if (cen_c == '0) begin
            win_d[0] = PAD; win_d[3] = PAD; win_d[6] = PAD;
        end
        if (cen_c == LAST_COL) begin
            win_d[2] = PAD; win_d[5] = PAD; win_d[8] = PAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STREAM;
            col_q        <= '0;
            row_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
        end else begin
            out_valid_q  <= emit;
            frame_done_q <= emit && (cen_r == LAST_ROW) && (cen_c == LAST_COL);
            if (emit) begin
                win_q <= win_d;
            end
            if (step) begin
                top_q <= {top_q[0], buf1_rd};
                mid_q <= {mid_q[0], buf0_rd};
                bot_q <= {bot_q[0], step_pixel};
            end
            col_q <= col_d;
            row_q <= row_d;

            case (state_q)
                ST_STREAM: begin
                    if (step && row_q == LAST_ROW && col_q == LAST_COL) begin
                        state_q    <= ST_FLUSH;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (row_q == FLUSH_END_ROW) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // These override the counter updates above for the next frame.
                    state_q    <= ST_STREAM;
                    in_ready_q <= 1'b1;
                    col_q      <= '0;
                    row_q      <= '0;
                end
                default: begin
                    state_q <= ST_STREAM;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign frame_done  = frame_done_q;
    assign out_pixel_1 = win_q[0];
    assign out_pixel_2 = win_q[1];
    assign out_pixel_3 = win_q[2];
    assign out_pixel_4 = win_q[3];
    assign out_pixel_5 = win_q[4];
    assign out_pixel_6 = win_q[5];
    assign out_pixel_7 = win_q[6];
    assign out_pixel_8 = win_q[7];
    assign out_pixel_9 = win_q[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
// Scoreboard bench: a 4x3 instance for the detailed scenarios and a 20x12
// instance for back-to-back frames with constant and random pixels.
module tb_window_3x3_generator;

    localparam logic [23:0] PAD = 24'hFFFFFF;
    localparam int SW = 4,  SH = 3;
    localparam int LW = 20, LH = 12;
    localparam int MODE_INDEX = 0, MODE_CONST = 1, MODE_RAND = 2;

    typedef struct packed {
        logic [8:0][23:0] p;
        logic             last;
    } win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_s, in_valid_l;
    logic [23:0] in_pixel;
    logic        in_ready_s, in_ready_l, out_valid_s, out_valid_l, frame_done_s, frame_done_l;
    logic [23:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;
    logic [23:0] l1, l2, l3, l4, l5, l6, l7, l8, l9;
    logic [215:0] win_s, win_l, last_s, last_l;

    logic [23:0] img [];
    win_t q_s [$];
    win_t q_l [$];
    bit   exp_emit_s = 1'b0, exp_emit_l = 1'b0;
    int   win_cnt_s, fd_cnt_s, win_cnt_l, fd_cnt_l;
    int   n_vec = 0, n_err = 0;

    assign win_s = {s9, s8, s7, s6, s5, s4, s3, s2, s1};
    assign win_l = {l9, l8, l7, l6, l5, l4, l3, l2, l1};

    always #5 clk = ~clk;

    window_3x3_generator #(.WIDTH(SW), .HEIGHT(SH), .PAD(PAD)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_pixel(in_pixel), .in_ready(in_ready_s),
        .out_valid(out_valid_s),
        .out_pixel_1(s1), .out_pixel_2(s2), .out_pixel_3(s3), .out_pixel_4(s4), .out_pixel_5(s5),
        .out_pixel_6(s6), .out_pixel_7(s7), .out_pixel_8(s8), .out_pixel_9(s9),
        .frame_done(frame_done_s)
    );

    window_3x3_generator #(.WIDTH(LW), .HEIGHT(LH), .PAD(PAD)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_pixel(in_pixel), .in_ready(in_ready_l),
        .out_valid(out_valid_l),
        .out_pixel_1(l1), .out_pixel_2(l2), .out_pixel_3(l3), .out_pixel_4(l4), .out_pixel_5(l5),
        .out_pixel_6(l6), .out_pixel_7(l7), .out_pixel_8(l8), .out_pixel_9(l9),
        .frame_done(frame_done_l)
    );

    task automatic check(input string tag, input logic [215:0] got, input logic [215:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected window built directly from frame coordinates.
    function automatic win_t model_window(input int w, input int h, input int k);
        win_t x;
        int r = k / w;
        int c = k % w;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                int pos = (dr + 1) * 3 + (dc + 1);
                x.p[pos] = (rr < 0 || rr >= h || cc < 0 || cc >= w) ? PAD : img[rr * w + cc];
            end
        end
        x.last = (k == w * h - 1);
        return x;
    endfunction

    function automatic bit ready(input bit big);
        return big ? in_ready_l : in_ready_s;
    endfunction

    task automatic drive(input bit big, input bit v, input logic [23:0] pix);
        if (big) in_valid_l = v; else in_valid_s = v;
        in_pixel = pix;
    endtask

    task automatic set_exp(input bit big, input bit e);
        if (big) exp_emit_l = e; else exp_emit_s = e;
    endtask

    task automatic push(input bit big, input win_t x);
        if (big) q_l.push_back(x); else q_s.push_back(x);
    endtask

    task automatic run_frame(input bit big, input int w, input int h, input int mode,
                             input int duty, input int abort_at);
        int k = 0;
        int guard = 0;
        int low = 0;
        bit v, acc;
        img = new[w * h];
        foreach (img[i]) begin
            case (mode)
                MODE_INDEX: img[i] = 24'(i);
                MODE_CONST: img[i] = 24'h102030;
                default:    img[i] = 24'($urandom());
            endcase
        end
        if (big) begin win_cnt_l = 0; fd_cnt_l = 0; end
        else     begin win_cnt_s = 0; fd_cnt_s = 0; end

        while (k < w * h && k != abort_at && guard < 20 * w * h) begin
            v = ($urandom_range(99) < duty);
            drive(big, v, img[k]);
            acc = v && ready(big);
            @(posedge clk);
            guard++;
            if (acc && k >= w + 1) push(big, model_window(w, h, k - w - 1));
            set_exp(big, acc && k >= w + 1);
            if (acc) k++;
            #1;
        end
        drive(big, 1'b0, 24'h0);

        if (k == abort_at) begin
            @(negedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            set_exp(big, 1'b0);
            #1 rst = 1'b0;
            check("abort_ready", ready(big), 1);
            check("abort_valid", big ? out_valid_l : out_valid_s, 0);
            check("abort_window", big ? win_l : win_s, 0);
            check("abort_sb_empty", big ? q_l.size() : q_s.size(), 0);
            return;
        end
        if (k < w * h) check("accept_progress", k, w * h);

        for (int i = 0; i <= w + 2; i++) begin
            if (!ready(big)) low++;
            @(posedge clk);
            if (i <= w) push(big, model_window(w, h, w * h - w - 1 + i));
            set_exp(big, i <= w);
            #1;
        end
        check("ready_low_cycles", low, w + 2);
        check("window_count", big ? win_cnt_l : win_cnt_s, w * h);
        check("frame_done_count", big ? fd_cnt_l : fd_cnt_s, 1);
        check("sb_empty", big ? q_l.size() : q_s.size(), 0);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            last_s = '0;
            last_l = '0;
        end
    end

    always @(negedge clk) begin : mon_s
        win_t e;
        if (!rst) begin
            check("s_out_valid", out_valid_s, exp_emit_s);
            if (out_valid_s) begin
                win_cnt_s++;
                if (frame_done_s) fd_cnt_s++;
                check("s_sb_nonempty", q_s.size() > 0, 1);
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    check("s_window", win_s, e.p);
                    check("s_frame_done", frame_done_s, e.last);
                end
                last_s = win_s;
            end else begin
                check("s_frame_done_idle", frame_done_s, 0);
                check("s_hold", win_s, last_s);
            end
        end
    end

    always @(negedge clk) begin : mon_l
        win_t e;
        if (!rst) begin
            check("l_out_valid", out_valid_l, exp_emit_l);
            if (out_valid_l) begin
                win_cnt_l++;
                if (frame_done_l) fd_cnt_l++;
                check("l_sb_nonempty", q_l.size() > 0, 1);
                if (q_l.size() > 0) begin
                    e = q_l.pop_front();
                    check("l_window", win_l, e.p);
                    check("l_frame_done", frame_done_l, e.last);
                end
                last_l = win_l;
            end else begin
                check("l_frame_done_idle", frame_done_l, 0);
                check("l_hold", win_l, last_l);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid_s = 1'b0;
        in_valid_l = 1'b0;
        in_pixel = 24'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready_s", in_ready_s, 1);
        check("rst_valid_s", out_valid_s, 0);
        check("rst_done_s", frame_done_s, 0);
        check("rst_window_s", win_s, 0);
        check("rst_ready_l", in_ready_l, 1);
        check("rst_valid_l", out_valid_l, 0);
        check("rst_window_l", win_l, 0);

        run_frame(1'b0, SW, SH, MODE_INDEX, 100, -1);
        run_frame(1'b0, SW, SH, MODE_INDEX, 50, -1);
        run_frame(1'b0, SW, SH, MODE_INDEX, 100, 7);
        run_frame(1'b0, SW, SH, MODE_INDEX, 100, -1);
        run_frame(1'b0, SW, SH, MODE_RAND, 60, -1);

        run_frame(1'b1, LW, LH, MODE_CONST, 100, -1);
        run_frame(1'b1, LW, LH, MODE_RAND, 70, -1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
